sram_stream_loader: RTL and testbench
=====================================

SRAM_STREAM_LOADER -- requirements
Module: sram_stream_loader

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 4, SRAM address width.
REQ-002 SHALL have parameter DATA_WIDTH, default 8, SRAM word width.
REQ-003 SHALL have parameter DEPTH, default 16, SRAM words; equals 2^ADDR_WIDTH.
REQ-004 SHALL have port clk  input  1  single clock; all logic on rising edge.
REQ-005 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-006 SHALL have port start  input  1  one-cycle request to begin a burst.
REQ-007 SHALL have port base_addr  input  ADDR_WIDTH  first SRAM address of the burst.
REQ-008 SHALL have port len  input  ADDR_WIDTH+1  number of words to read, 0..DEPTH.
REQ-009 SHALL have port busy  output  1  burst in progress.
REQ-010 SHALL have port done  output  1  one-cycle pulse at burst end.
REQ-011 SHALL have port sram_cs  output  1  SRAM chip select.
REQ-012 SHALL have port sram_we  output  1  SRAM write enable.
REQ-013 SHALL have port sram_addr  output  ADDR_WIDTH  SRAM address.
REQ-014 SHALL have port sram_din  output  DATA_WIDTH  SRAM write data.
REQ-015 SHALL have port sram_dout  input  DATA_WIDTH  SRAM read data; valid only while cs=1 and we=0, one cycle after the address is presented.
REQ-016 SHALL have port out_valid  output  1  out_data holds a word.
REQ-017 SHALL have port out_ready  input  1  downstream accepts the word.
REQ-018 SHALL have port out_data  output  DATA_WIDTH  streamed word.

Function
REQ-019 SHALL hold sram_we=0 and sram_din=0 at all times; the block only reads.
REQ-020 SHALL implement states IDLE, RUN, FINISH; IDLE->RUN on start while IDLE and len!=0; IDLE->FINISH on start with len=0; RUN->FINISH when the last word is accepted on the output; FINISH->IDLE unconditionally after one cycle.
REQ-021 SHALL sample base_addr and len only in the cycle start=1 is seen in IDLE; a start in RUN or FINISH SHALL be ignored.
REQ-022 SHALL clamp len>DEPTH to DEPTH.
REQ-023 SHALL issue read k (k=0..len-1) at address (base_addr+k) mod 2^ADDR_WIDTH; wrap-around past DEPTH-1 to 0 is legal.
REQ-024 SHALL issue a read in a cycle only when words remain and (output buffer occupancy + reads in flight - pop this cycle) <= 1.
REQ-025 SHALL hold sram_cs=1 from the first issued read through the cycle each in-flight word is captured, so that sram_dout is driven; sram_cs SHALL be 0 otherwise.
REQ-026 SHALL capture sram_dout into a 2-entry FIFO in the cycle after the matching read issue; the FIFO SHALL never overflow.
REQ-027 SHALL drive out_valid from FIFO non-empty and out_data from FIFO head; a word leaves on out_valid&out_ready.
REQ-028 SHALL keep out_data stable while out_valid=1 and out_ready=0.
REQ-029 SHALL produce out_valid no earlier than 3 cycles after start (start cycle 0: issue cycle 1, capture cycle 2, out_valid cycle 3).
REQ-030 SHALL sustain one word per cycle when out_ready is held high.
REQ-031 SHALL assert busy in RUN only; done SHALL be 1 exactly in the FINISH cycle.
REQ-032 SHALL deliver words in address order with no duplication or loss under any out_ready pattern.

Reset
REQ-033 SHALL, on rst=1 at a clock edge, enter IDLE, flush the FIFO, cancel in-flight reads, and drive busy=0, done=0, out_valid=0, sram_cs=0, sram_addr=0, out_data=0.
REQ-034 SHALL abort any burst when rst asserts mid-operation, producing no done pulse and no further output words.

Verification
REQ-035 SHALL pass: SRAM preloaded mem[i]=i+0x10, start with base=0, len=16, out_ready=1 -> out_data 0x10..0x1F on cycles 3..18, done at cycle 19, busy 1..18.
REQ-036 SHALL pass: base=14, len=4 -> addresses 14,15,0,1; data 0x1E,0x1F,0x10,0x11.
REQ-037 SHALL pass: len=8, out_ready toggles 1/0 each cycle -> 8 words in order, out_data stable during stalls, at most 2 reads ahead of output.
REQ-038 SHALL pass: start with len=0 -> no sram_cs, no out_valid, done=1 next cycle; len=20 -> exactly 16 words.
REQ-039 SHALL pass: rst asserted at cycle 6 of a len=16 burst -> next cycle all outputs at reset values, no done; a fresh start then runs normally.
REQ-040 SHALL pass: start pulsed during RUN with different base_addr -> ignored, current burst unaffected.

Source files
------------

// File: rtl/sram_stream_loader_if.sv
// Bundles the burst-control, SRAM and output-stream signals of the SRAM stream loader.
// The master modport is the loader's view; the slave modport is the surrounding system's view.
interface sram_stream_loader_if #(
   parameter int ADDR_WIDTH = 4,
   parameter int DATA_WIDTH = 8
);
   logic                  start;
   logic [ADDR_WIDTH-1:0] base_addr;
   logic [ADDR_WIDTH:0]   len;
   logic                  busy;
   logic                  done;
   logic                  sram_cs;
   logic                  sram_we;
   logic [ADDR_WIDTH-1:0] sram_addr;
   logic [DATA_WIDTH-1:0] sram_din;
   logic [DATA_WIDTH-1:0] sram_dout;
   logic                  out_valid;
   logic                  out_ready;
   logic [DATA_WIDTH-1:0] out_data;

   modport master (
      input  start, base_addr, len, sram_dout, out_ready,
      output busy, done, sram_cs, sram_we, sram_addr, sram_din, out_valid, out_data
   );

   modport slave (
      output start, base_addr, len, sram_dout, out_ready,
      input  busy, done, sram_cs, sram_we, sram_addr, sram_din, out_valid, out_data
   );
endinterface

// File: rtl/sram_stream_loader.sv
// Reads a burst of consecutive SRAM words (address wraps modulo 2^ADDR_WIDTH) and streams
// them out through a 2-entry FIFO with valid/ready flow control.
module sram_stream_loader #(
   parameter int ADDR_WIDTH = 4,
   parameter int DATA_WIDTH = 8,
   parameter int DEPTH      = 16
) (
   input logic clk,
   input logic rst,
   sram_stream_loader_if.master bus
);
   typedef enum logic [1:0] {IDLE, RUN, FINISH} state_t;

   state_t                state, state_next;
   logic [ADDR_WIDTH-1:0] rd_addr;
   logic [ADDR_WIDTH:0]   issue_left;
   logic [ADDR_WIDTH:0]   deliver_left;
   logic                  inflight;
   logic [DATA_WIDTH-1:0] fifo_mem [2];
   logic                  wr_ptr, rd_ptr;
   logic [1:0]            count;
   logic [ADDR_WIDTH:0]   len_clamped;
   logic                  start_accept, pop, issue, busy, done;

   assign len_clamped  = (bus.len > (ADDR_WIDTH+1)'(DEPTH)) ? (ADDR_WIDTH+1)'(DEPTH) : bus.len;
   assign start_accept = (state == IDLE) && bus.start;
   assign pop          = (count != 2'd0) && bus.out_ready;

   // Issuing only while buffered plus in-flight words, after this cycle's pop, stay <= 1
   // guarantees the capture next cycle always finds room in the 2-entry FIFO.
   assign issue = (state == RUN) && (issue_left != '0) &&
                  (({1'b0, count} + {2'b0, inflight}) <= (3'd1 + {2'b0, pop}));

   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_next;
   end

   always_comb begin
      state_next = state;
      busy       = 1'b0;
      done       = 1'b0;
      case (state)
         IDLE: begin
            if (bus.start) state_next = (len_clamped != '0) ? RUN : FINISH;
         end
         RUN: begin
            busy = 1'b1;
            if (pop && (deliver_left == (ADDR_WIDTH+1)'(1))) state_next = FINISH;
         end
         FINISH: begin
            done       = 1'b1;
            state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   // Read pointer/counters, the one-cycle read pipeline stage and the output FIFO.
   always_ff @(posedge clk) begin
      if (rst) begin
         rd_addr      <= '0;
         issue_left   <= '0;
         deliver_left <= '0;
         inflight     <= 1'b0;
         fifo_mem[0]  <= '0;
         fifo_mem[1]  <= '0;
         wr_ptr       <= 1'b0;
         rd_ptr       <= 1'b0;
         count        <= 2'd0;
      end else begin
         if (start_accept) begin
            rd_addr      <= bus.base_addr;
            issue_left   <= len_clamped;
            deliver_left <= len_clamped;
         end else begin
            if (issue) begin
               rd_addr    <= rd_addr + 1'b1;
               issue_left <= issue_left - 1'b1;
            end
            if (pop) deliver_left <= deliver_left - 1'b1;
         end
         inflight <= issue;
         if (inflight) begin
            fifo_mem[wr_ptr] <= bus.sram_dout;
            wr_ptr           <= ~wr_ptr;
         end
         if (pop) rd_ptr <= ~rd_ptr;
         count <= count + {1'b0, inflight} - {1'b0, pop};
      end
   end

   assign bus.busy      = busy;
   assign bus.done      = done;
   assign bus.sram_cs   = issue || inflight;
   assign bus.sram_we   = 1'b0;
   assign bus.sram_din  = '0;
   assign bus.sram_addr = issue ? rd_addr : '0;
   assign bus.out_valid = (count != 2'd0);
   assign bus.out_data  = (count != 2'd0) ? fifo_mem[rd_ptr] : '0;
endmodule

// File: tb/tb_sram_stream_loader.sv
// Directed bench for sram_stream_loader: an SRAM model, a queue of expected words derived
// from the memory contents, and a per-cycle compare process for the output stream.
module tb_sram_stream_loader;
   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   sram_stream_loader_if #(.ADDR_WIDTH(4), .DATA_WIDTH(8)) bus ();

   sram_stream_loader #(.ADDR_WIDTH(4), .DATA_WIDTH(8), .DEPTH(16)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   logic [7:0] mem [16];
   logic [7:0] expQ [$];
   logic [7:0] wordLog [$];
   int         testsRun = 0;
   int         testsFailed = 0;

   int         firstValid, doneCycle, doneCount, busyFirst, busyLast, validAfterRst;
   bit         csSeen;
   logic [3:0] addrTrace [64];
   logic       csTrace [64];
   logic       prevStall = 1'b0;
   logic [7:0] prevData = '0;

   // Synchronous-read SRAM: data appears the cycle after a selected read address.
   always @(posedge clk) begin
      if (bus.sram_cs && !bus.sram_we) bus.sram_dout <= mem[bus.sram_addr];
   end

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      testsRun++;
      if (actual !== expected) begin
         testsFailed++;
         $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
      end
   endtask

   always @(negedge clk) begin
      checkOutput("we_din_zero", {23'd0, bus.sram_we, bus.sram_din}, 32'd0);
      if (!rst) begin
         if (prevStall) begin
            checkOutput("stall_valid", {31'd0, bus.out_valid}, 32'd1);
            checkOutput("stall_data", {24'd0, bus.out_data}, {24'd0, prevData});
         end
         if (bus.out_valid) begin
            if (expQ.size() == 0) begin
               checkOutput("unexpected_word", {31'd0, bus.out_valid}, 32'd0);
            end else begin
               checkOutput("out_data", {24'd0, bus.out_data}, {24'd0, expQ[0]});
               if (bus.out_ready) begin
                  void'(expQ.pop_front());
                  wordLog.push_back(bus.out_data);
               end
            end
         end
         prevStall = bus.out_valid && !bus.out_ready;
         prevData  = bus.out_data;
      end else begin
         prevStall = 1'b0;
      end
   end

   // readyMode 0 holds out_ready high, 1 toggles it every cycle; rstAt/restartAt < 0 disable
   // the mid-burst reset and the ignored second start.
   task automatic applyStimulus(input logic [3:0] base, input logic [4:0] len, input int readyMode,
                                input int rstAt, input int restartAt, input int maxCycles);
      int n;
      @(posedge clk); #1;
      bus.start     = 1'b1;
      bus.base_addr = base;
      bus.len       = len;
      bus.out_ready = 1'b1;
      n = (len > 5'd16) ? 16 : int'(len);
      wordLog.delete();
      for (int k = 0; k < n; k++) expQ.push_back(mem[(int'(base) + k) % 16]);
      firstValid = -1; doneCycle = -1; doneCount = 0;
      busyFirst = -1; busyLast = -1; validAfterRst = 0; csSeen = 1'b0;
      for (int i = 0; i < 64; i++) begin
         addrTrace[i] = '0;
         csTrace[i]   = 1'b0;
      end
      @(negedge clk);
      for (int cyc = 1; cyc <= maxCycles; cyc++) begin
         @(posedge clk); #1;
         bus.start = 1'b0;
         if (cyc == restartAt) begin
            bus.start     = 1'b1;
            bus.base_addr = 4'd7;
            bus.len       = 5'd3;
         end
         if (readyMode == 1) bus.out_ready = ~bus.out_ready;
         if (cyc == rstAt) rst = 1'b1;
         if (rstAt >= 0 && cyc == rstAt + 1) begin
            rst = 1'b0;
            expQ.delete();
         end
         @(negedge clk);
         if (cyc < 64) begin
            addrTrace[cyc] = bus.sram_addr;
            csTrace[cyc]   = bus.sram_cs;
         end
         if (bus.done) begin
            doneCount++;
            if (doneCycle < 0) doneCycle = cyc;
         end
         if (bus.busy) begin
            if (busyFirst < 0) busyFirst = cyc;
            busyLast = cyc;
         end
         if (bus.out_valid && firstValid < 0) firstValid = cyc;
         if (bus.sram_cs) csSeen = 1'b1;
         if (rstAt >= 0 && cyc > rstAt && bus.out_valid) validAfterRst++;
         if (rstAt >= 0 && cyc == rstAt + 1) begin
            checkOutput("rst_outputs",
                        {13'd0, bus.busy, bus.done, bus.out_valid, bus.sram_cs, bus.sram_addr, bus.out_data},
                        32'd0);
         end
         if (doneCycle >= 0 && cyc >= doneCycle + 2) break;
      end
      bus.start     = 1'b0;
      bus.out_ready = 1'b1;
   endtask

   initial begin
      for (int i = 0; i < 16; i++) mem[i] = 8'h10 + 8'(i);
      bus.start     = 1'b0;
      bus.base_addr = '0;
      bus.len       = '0;
      bus.out_ready = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      checkOutput("reset_state",
                  {13'd0, bus.busy, bus.done, bus.out_valid, bus.sram_cs, bus.sram_addr, bus.out_data},
                  32'd0);
      @(posedge clk); #1;
      rst = 1'b0;
      @(negedge clk);

      $display("[TB] full burst base=0 len=16");
      applyStimulus(4'd0, 5'd16, 0, -1, -1, 40);
      checkOutput("full_first_valid", firstValid, 3);
      checkOutput("full_done_cycle", doneCycle, 19);
      checkOutput("full_done_count", doneCount, 1);
      checkOutput("full_busy_first", busyFirst, 1);
      checkOutput("full_busy_last", busyLast, 18);
      checkOutput("full_words", wordLog.size(), 16);
      if (wordLog.size() == 16) begin
         checkOutput("full_word0", {24'd0, wordLog[0]}, 32'h10);
         checkOutput("full_word15", {24'd0, wordLog[15]}, 32'h1F);
      end

      $display("[TB] wrapping burst base=14 len=4");
      applyStimulus(4'd14, 5'd4, 0, -1, -1, 30);
      checkOutput("wrap_cs1", {31'd0, csTrace[1]}, 32'd1);
      checkOutput("wrap_addr1", {28'd0, addrTrace[1]}, 32'd14);
      checkOutput("wrap_addr3", {28'd0, addrTrace[3]}, 32'd0);
      checkOutput("wrap_words", wordLog.size(), 4);
      if (wordLog.size() == 4) begin
         checkOutput("wrap_word0", {24'd0, wordLog[0]}, 32'h1E);
         checkOutput("wrap_word2", {24'd0, wordLog[2]}, 32'h10);
         checkOutput("wrap_word3", {24'd0, wordLog[3]}, 32'h11);
      end
      checkOutput("wrap_done_cycle", doneCycle, 7);

      $display("[TB] toggling out_ready len=8");
      applyStimulus(4'd2, 5'd8, 1, -1, -1, 60);
      checkOutput("toggle_words", wordLog.size(), 8);
      checkOutput("toggle_done_count", doneCount, 1);
      checkOutput("toggle_queue_empty", expQ.size(), 0);

      $display("[TB] zero length");
      applyStimulus(4'd5, 5'd0, 0, -1, -1, 10);
      checkOutput("zero_done_cycle", doneCycle, 1);
      checkOutput("zero_cs", {31'd0, csSeen}, 32'd0);
      checkOutput("zero_valid", firstValid, -1);

      $display("[TB] oversize length 20");
      applyStimulus(4'd0, 5'd20, 0, -1, -1, 40);
      checkOutput("clamp_words", wordLog.size(), 16);
      checkOutput("clamp_done_cycle", doneCycle, 19);

      $display("[TB] reset mid-burst");
      applyStimulus(4'd0, 5'd16, 0, 6, -1, 25);
      checkOutput("abort_done_count", doneCount, 0);
      checkOutput("abort_valid_after", validAfterRst, 0);
      checkOutput("abort_words", wordLog.size(), 3);
      applyStimulus(4'd3, 5'd4, 0, -1, -1, 30);
      checkOutput("after_rst_words", wordLog.size(), 4);
      if (wordLog.size() == 4) checkOutput("after_rst_word0", {24'd0, wordLog[0]}, 32'h13);
      checkOutput("after_rst_done_cycle", doneCycle, 7);

      $display("[TB] start during run ignored");
      applyStimulus(4'd0, 5'd16, 0, -1, 5, 40);
      checkOutput("restart_words", wordLog.size(), 16);
      if (wordLog.size() == 16) checkOutput("restart_word7", {24'd0, wordLog[7]}, 32'h17);
      checkOutput("restart_done_cycle", doneCycle, 19);
      checkOutput("restart_done_count", doneCount, 1);

      repeat (3) @(posedge clk);
      $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
      $finish;
   end
endmodule
